freq_meas_sequencer: RTL

//   Top-level controller of the low-frequency counter. It runs the measurement chain in order:

---
 rtl/freq_meas_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/freq_meas_sequencer.sv
// rtl/freq_meas_sequencer.sv - controller for the low-frequency counter measurement chain
//
// Purpose: runs period counter -> divider -> bin-to-BCD converter in order,
// each through a start/done handshake, with a watchdog on the period measurement.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start                      1-cycle measurement request (honoured only when ready)
//   pc_hold, pc_clr            period counter freeze / 1-cycle clear
//   period_done, period_in     period counter result (us)
//   div_start, div_dividend,
//   div_divisor                divider request; dividend is the constant DIVIDEND
//   div_done, div_quo          divider result (Hz)
//   bcd_start, freq_bin        BCD converter request; freq_bin holds the last quotient
//   bcd_done                   BCD converter finished
//   ready, done_tick           idle flag / 1-cycle result-valid pulse
//   err_timeout, err_zero      sticky error flags, cleared by the next accepted start
module freq_meas_sequencer #(
  parameter int COUNTER_WIDTH = 24,
  parameter int DIVIDEND      = 1_000_000,
  parameter int TICKS_PER_US  = 100,
  parameter int TIMEOUT_US    = 2_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     pc_hold,
  output logic                     pc_clr,
  input  logic                     period_done,
  input  logic [COUNTER_WIDTH-1:0] period_in,
  output logic                     div_start,
  output logic [COUNTER_WIDTH-1:0] div_dividend,
  output logic [COUNTER_WIDTH-1:0] div_divisor,
  input  logic                     div_done,
  input  logic [COUNTER_WIDTH-1:0] div_quo,
  output logic                     bcd_start,
  output logic [COUNTER_WIDTH-1:0] freq_bin,
  input  logic                     bcd_done,
  output logic                     ready,
  output logic                     done_tick,
  output logic                     err_timeout,
  output logic                     err_zero
);

  localparam int TK_W = $clog2(TICKS_PER_US + 1);
  localparam int US_W = $clog2(TIMEOUT_US + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MEAS, S_DIV, S_BCD} state_t;

  state_t                   state_q, state_d;
  logic [TK_W-1:0]          tick_q, tick_d;
  logic [US_W-1:0]          us_q, us_d;
  logic [COUNTER_WIDTH-1:0] divisor_q, divisor_d;
  logic [COUNTER_WIDTH-1:0] freq_q, freq_d;
  logic                     err_to_q, err_to_d;
  logic                     err_zero_q, err_zero_d;
  logic                     pc_hold_q, pc_hold_d;
  logic                     pc_clr_q, pc_clr_d;
  logic                     ready_q, ready_d;
  logic                     div_start_q, div_start_d;
  logic                     bcd_start_q, bcd_start_d;
  logic                     done_tick_q, done_tick_d;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    us_d       = us_q;
    divisor_d  = divisor_q;
    freq_d     = freq_q;
    err_to_d   = err_to_q;
    err_zero_d = err_zero_q;
    done_tick_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLR;
          err_to_d   = 1'b0;
          err_zero_d = 1'b0;
        end
      end
      S_CLR: begin
        tick_d  = '0;
        us_d    = '0;
        state_d = S_MEAS;
      end
      S_MEAS: begin
        if (tick_q == TK_W'(TICKS_PER_US - 1)) begin
          tick_d = '0;
          us_d   = us_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        // period_done is checked first so it wins a tie with the watchdog
        if (period_done) begin
          if (period_in != '0) begin
            divisor_d = period_in;
            state_d   = S_DIV;
          end else begin
            err_zero_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (us_q == US_W'(TIMEOUT_US)) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DIV: begin
        if (div_done) begin
          freq_d  = div_quo;
          state_d = S_BCD;
        end
      end
      S_BCD: begin
        if (bcd_done) begin
          done_tick_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they register alongside it
    pc_hold_d   = (state_d != S_MEAS);
    pc_clr_d    = (state_d == S_CLR);
    ready_d     = (state_d == S_IDLE);
    div_start_d = (state_d == S_DIV) && (state_q != S_DIV);
    bcd_start_d = (state_d == S_BCD) && (state_q != S_BCD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      us_q        <= '0;
      divisor_q   <= '0;
      freq_q      <= '0;
      err_to_q    <= 1'b0;
      err_zero_q  <= 1'b0;
      pc_hold_q   <= 1'b1;
      pc_clr_q    <= 1'b0;
      ready_q     <= 1'b1;
      div_start_q <= 1'b0;
      bcd_start_q <= 1'b0;
      done_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      us_q        <= us_d;
      divisor_q   <= divisor_d;
      freq_q      <= freq_d;
      err_to_q    <= err_to_d;
      err_zero_q  <= err_zero_d;
      pc_hold_q   <= pc_hold_d;
      pc_clr_q    <= pc_clr_d;
      ready_q     <= ready_d;
      div_start_q <= div_start_d;
      bcd_start_q <= bcd_start_d;
      done_tick_q <= done_tick_d;
    end
  end

  assign pc_hold      = pc_hold_q;
  assign pc_clr       = pc_clr_q;
  assign div_start    = div_start_q;
  assign div_dividend = COUNTER_WIDTH'(DIVIDEND);
  assign div_divisor  = divisor_q;
  assign bcd_start    = bcd_start_q;
  assign freq_bin     = freq_q;
  assign ready        = ready_q;
  assign done_tick    = done_tick_q;
  assign err_timeout  = err_to_q;
  assign err_zero     = err_zero_q;

endmodule
